// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: issues a burst of SRAM reads and streams the returned
// complex 4-lane words out through a 2-entry valid/ready FIFO.
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif

module sram_rd_streamer #(
  parameter int SfpWidth   = `SFP_WIDTH,
  parameter int AddrLWidth = 7,
  parameter int AddrSWidth = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            mode_i,
  input  logic [AddrLWidth-1:0] base_i,
  input  logic [AddrLWidth:0]   len_i,
  output logic [2:0]            sram_cs_rd_o,
  output logic [AddrLWidth-1:0] sram_addr_rd_o,
  input  logic [4*SfpWidth-1:0] dr_sram_i,
  input  logic [4*SfpWidth-1:0] di_sram_i,
  output logic [4*SfpWidth-1:0] dr_o,
  output logic [4*SfpWidth-1:0] di_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam logic [AddrLWidth-1:0] SMask = {{(AddrLWidth-AddrSWidth){1'b0}}, {AddrSWidth{1'b1}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [2:0] mode_q;
  logic [AddrLWidth-1:0] addr_q, addr_nxt, in_mask, run_mask;
  logic [AddrLWidth:0] remaining;
  logic inflight, inflight_last, issue, last_issue, pop, head_last, done_q;
  logic [4*SfpWidth-1:0] mem_r [2];
  logic [4*SfpWidth-1:0] mem_i [2];
  logic [1:0] mem_l, count, occ;
  logic wr_ptr, rd_ptr;
  assign in_mask    = (mode_i == 3'b000) ? '1 : SMask;
  assign run_mask   = (mode_q == 3'b000) ? '1 : SMask;
  assign addr_nxt   = (addr_q + AddrLWidth'(1)) & run_mask;
  assign valid_o    = count != 2'd0;
  assign pop        = valid_o & ready_i;
  assign head_last  = mem_l[rd_ptr];
  // occupancy the FIFO will have next cycle if nothing else is issued
  assign occ        = count + {1'b0, inflight} - {1'b0, pop};
  assign issue      = (state == RUN) && (remaining != '0) && (occ < 2'd2);
  assign last_issue = issue && (remaining == (AddrLWidth+1)'(1));
  assign dr_o       = mem_r[rd_ptr];
  assign di_o       = mem_i[rd_ptr];
  assign last_o     = valid_o & head_last;
  assign busy_o     = state != IDLE;
  assign done_o     = done_q;
  assign sram_cs_rd_o   = busy_o ? mode_q : 3'b000;
  assign sram_addr_rd_o = busy_o ? addr_q : '0;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start_i && len_i != '0) state_nxt = RUN;
    else if (state == RUN && last_issue) state_nxt = DRAIN;
    else if (state == DRAIN && pop && head_last) state_nxt = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      mode_q        <= '0;
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
      mem_r[0]      <= '0;
      mem_r[1]      <= '0;
      mem_i[0]      <= '0;
      mem_i[1]      <= '0;
      mem_l         <= '0;
      count         <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
    end else begin
      state         <= state_nxt;
      done_q        <= (state == IDLE && start_i && len_i == '0) || (state == DRAIN && pop && head_last);
      inflight      <= issue;
      inflight_last <= last_issue;
      count         <= occ;
      if (state == IDLE && start_i) begin
        mode_q    <= mode_i;
        addr_q    <= base_i & in_mask;
        remaining <= len_i;
      end else if (issue) begin
        remaining <= remaining - (AddrLWidth+1)'(1);
        if (!last_issue) addr_q <= addr_nxt;
      end
      if (inflight) begin
        mem_r[wr_ptr] <= dr_sram_i;
        mem_i[wr_ptr] <= di_sram_i;
        mem_l[wr_ptr] <= inflight_last;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: directed scenarios for sram_rd_streamer against a
// one-cycle-latency SRAM whose words encode select code, address and lane.
module tb_sram_rd_streamer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  logic [2:0] mode = '0;
  logic [6:0] base = '0;
  logic [7:0] len = '0;
  logic [2:0] cs;
  logic [6:0] addr;
  logic [63:0] dr_sram = '0, di_sram = '0, dr, di;
  logic valid, last, busy, done;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] got_dr [64];
  logic [63:0] got_di [64];
  logic got_last [64];
  int got_cyc [64];
  logic [6:0] addr_tr [128];
  logic [2:0] cs_tr [128];
  logic busy_tr [128];
  int nbeat, done_at, done_cnt, stall_bad, busy_any;

  sram_rd_streamer #(.SfpWidth(16), .AddrLWidth(7), .AddrSWidth(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .base_i(base), .len_i(len),
    .sram_cs_rd_o(cs), .sram_addr_rd_o(addr), .dr_sram_i(dr_sram), .di_sram_i(di_sram),
    .dr_o(dr), .di_o(di), .valid_o(valid), .ready_i(ready), .last_o(last),
    .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [2:0] c, input logic [6:0] a);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = {4'hA ^ 4'(k), c, a, 2'(k)};
    return w;
  endfunction

  always @(posedge clk) begin
    dr_sram <= word(cs, addr);
    di_sram <= ~word(cs, addr);
  end

  task automatic kick(input logic [2:0] m, input logic [6:0] b, input logic [7:0] l);
    @(negedge clk);
    start = 1'b1; mode = m; base = b; len = l;
  endtask

  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1. inj_k: cycle to pulse a stray start.
  task automatic collect(input int rmode, input int inj_k, input int maxc);
    logic prev_stall = 1'b0;
    logic [63:0] p_dr = '0, p_di = '0;
    logic p_last = 1'b0;
    nbeat = 0; done_at = -1; done_cnt = 0; stall_bad = 0; busy_any = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) begin mode = 3'd0; base = 7'd50; len = 8'd3; end
      ready = (rmode == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
      if (k < 128) begin addr_tr[k] = addr; cs_tr[k] = cs; busy_tr[k] = busy; end
      if (busy) busy_any = 1;
      if (done) begin if (done_at < 0) done_at = k; done_cnt++; end
      if (prev_stall && (dr !== p_dr || di !== p_di || last !== p_last || !valid)) stall_bad++;
      prev_stall = valid && !ready;
      p_dr = dr; p_di = di; p_last = last;
      if (valid && ready && nbeat < 64) begin
        got_dr[nbeat] = dr; got_di[nbeat] = di; got_last[nbeat] = last; got_cyc[nbeat] = k;
        nbeat++;
      end
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    start = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if ({valid, last, busy, done} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {valid, last, busy, done}); end
    n_cmp++; if ({dr, di, cs, addr} !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", {dr, di, cs, addr}); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    kick(3'd0, 7'd5, 8'd4);
    collect(0, -1, 40);
    n_cmp++; if (nbeat !== 4) begin n_bad++; $display("FAIL basic_beats got %0d want 4", nbeat); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_tr[i] !== 7'(5 + i)) begin n_bad++; $display("FAIL basic_addr%0d got %0d want %0d", i, addr_tr[i], 5 + i); end
      n_cmp++; if (got_cyc[i] !== 2 + i) begin n_bad++; $display("FAIL basic_cyc%0d got %0d want %0d", i, got_cyc[i], 2 + i); end
      n_cmp++; if (got_dr[i] !== word(3'd0, 7'(5 + i)) || got_di[i] !== ~word(3'd0, 7'(5 + i))) begin n_bad++; $display("FAIL basic_data%0d got %h/%h want %h", i, got_dr[i], got_di[i], word(3'd0, 7'(5 + i))); end
      n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL basic_last%0d got %b want %b", i, got_last[i], i == 3); end
    end
    n_cmp++; if (done_at !== 6 || done_cnt !== 1) begin n_bad++; $display("FAIL basic_done got at %0d x%0d want at 6 x1", done_at, done_cnt); end
    n_cmp++; if (busy_tr[0] !== 1'b1 || busy_tr[6] !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b%b want 10", busy_tr[0], busy_tr[6]); end
    n_cmp++; if (addr_tr[6] !== 7'd0 || cs_tr[6] !== 3'd0) begin n_bad++; $display("FAIL basic_idle_bus got %0d/%0d want 0/0", addr_tr[6], cs_tr[6]); end
  endtask

  task automatic test_short_wrap;
    logic [6:0] ea [4];
    ea[0] = 7'd30; ea[1] = 7'd31; ea[2] = 7'd0; ea[3] = 7'd1;
    kick(3'd2, 7'd30, 8'd4);
    collect(0, -1, 40);
    n_cmp++; if (nbeat !== 4) begin n_bad++; $display("FAIL wrap_beats got %0d want 4", nbeat); end
    n_cmp++; if (cs_tr[0] !== 3'd2) begin n_bad++; $display("FAIL wrap_cs got %0d want 2", cs_tr[0]); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_tr[i] !== ea[i]) begin n_bad++; $display("FAIL wrap_addr%0d got %0d want %0d", i, addr_tr[i], ea[i]); end
      n_cmp++; if (got_dr[i] !== word(3'd2, ea[i]) || got_di[i] !== ~word(3'd2, ea[i])) begin n_bad++; $display("FAIL wrap_data%0d got %h want %h", i, got_dr[i], word(3'd2, ea[i])); end
    end
  endtask

  task automatic test_stall;
    kick(3'd0, 7'd120, 8'd10);
    collect(1, -1, 100);
    n_cmp++; if (nbeat !== 10) begin n_bad++; $display("FAIL stall_beats got %0d want 10", nbeat); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (got_dr[i] !== word(3'd0, 7'(120 + i)) || got_di[i] !== ~word(3'd0, 7'(120 + i))) begin n_bad++; $display("FAIL stall_data%0d got %h want %h", i, got_dr[i], word(3'd0, 7'(120 + i))); end
      n_cmp++; if (got_last[i] !== (i == 9)) begin n_bad++; $display("FAIL stall_last%0d got %b want %b", i, got_last[i], i == 9); end
    end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_bad); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_zero_len;
    kick(3'd0, 7'd9, 8'd0);
    collect(0, -1, 20);
    n_cmp++; if (nbeat !== 0) begin n_bad++; $display("FAIL zero_beats got %0d want 0", nbeat); end
    n_cmp++; if (done_at !== 0 || done_cnt !== 1) begin n_bad++; $display("FAIL zero_done got at %0d x%0d want at 0 x1", done_at, done_cnt); end
    n_cmp++; if (busy_any !== 0) begin n_bad++; $display("FAIL zero_busy got %0d want 0", busy_any); end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    kick(3'd0, 7'd10, 8'd8);
    for (int k = 0; k < 3; k++) begin @(negedge clk); start = 1'b0; ready = 1'b1; end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid got %b want 1", valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({valid, last, busy, done} !== 4'b0) begin n_bad++; $display("FAIL rstmid_flags got %b want 0000", {valid, last, busy, done}); end
    n_cmp++; if ({dr, di, cs, addr} !== '0) begin n_bad++; $display("FAIL rstmid_data got %h want 0", {dr, di, cs, addr}); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done || valid || busy) stray++; end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL rstmid_quiet got %0d active cycles want 0", stray); end
    kick(3'd0, 7'd40, 8'd2);
    collect(0, -1, 30);
    n_cmp++; if (nbeat !== 2) begin n_bad++; $display("FAIL rstmid_beats got %0d want 2", nbeat); end
    n_cmp++; if (got_dr[0] !== word(3'd0, 7'd40) || got_dr[1] !== word(3'd0, 7'd41)) begin n_bad++; $display("FAIL rstmid_data2 got %h %h want %h %h", got_dr[0], got_dr[1], word(3'd0, 7'd40), word(3'd0, 7'd41)); end
    n_cmp++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || done_cnt !== 1) begin n_bad++; $display("FAIL rstmid_last got %b%b x%0d want 01 x1", got_last[0], got_last[1], done_cnt); end
  endtask

  task automatic test_busy_start;
    logic [6:0] ea [4];
    ea[0] = 7'd30; ea[1] = 7'd31; ea[2] = 7'd0; ea[3] = 7'd1;
    kick(3'd7, 7'd126, 8'd4);
    collect(0, 1, 40);
    n_cmp++; if (nbeat !== 4) begin n_bad++; $display("FAIL busy_beats got %0d want 4", nbeat); end
    n_cmp++; if (cs_tr[2] !== 3'd7) begin n_bad++; $display("FAIL busy_cs got %0d want 7", cs_tr[2]); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (addr_tr[i] !== ea[i]) begin n_bad++; $display("FAIL busy_addr%0d got %0d want %0d", i, addr_tr[i], ea[i]); end
      n_cmp++; if (got_dr[i] !== word(3'd7, ea[i])) begin n_bad++; $display("FAIL busy_data%0d got %h want %h", i, got_dr[i], word(3'd7, ea[i])); end
    end
    n_cmp++; if (done_cnt !== 1 || busy_tr[done_at + 2] !== 1'b0) begin n_bad++; $display("FAIL busy_end got x%0d busy %b want x1 busy 0", done_cnt, busy_tr[done_at + 2]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_short_wrap;
    test_stall;
    test_zero_len;
    test_reset_mid;
    test_busy_start;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
